idli_trc_m: RTL

// - Synthesisable retire-trace unit; sits beside EX and snoops its per-instruction side effects.
// - Accumulates a scoreboard for each instruction:
//   - GPR writes;
//   - predicate write and value;
//   - output-pin writes;
//   - PC.
// - On retire, pushes one record into a DEPTH-entry FIFO, drained by a valid/ready consumer
//   (debug UART bridge or bench).
// - Replaces ad-hoc scoreboard flops with a parametrised, loss-reporting trace path.

---
 rtl/idli_trc_m.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/idli_trc_m.sv
// idli_trc_m - retire-trace unit: per-instruction scoreboard pushed into a DEPTH-entry record FIFO.
// Optional retire timestamps are enabled by defining IDLI_TRC_TSTAMP_EN.
module idli_trc_m #(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = 16,
  parameter int NUM_PINS = 4,
  parameter int DATA_W   = 16,
  parameter int TS_W     = 16
) (
  input  logic                        i_trc_gck,
  input  logic                        i_trc_rst_n,
  input  logic                        i_trc_new,
  input  logic [DATA_W-1:0]           i_trc_pc,
  input  logic                        i_trc_reg_wr,
  input  logic [$clog2(NUM_REGS)-1:0] i_trc_reg_idx,
  input  logic                        i_trc_pred_wr,
  input  logic                        i_trc_pred_val,
  input  logic [NUM_PINS-1:0]         i_trc_pin_wr,
  input  logic                        i_trc_retire,
  input  logic                        i_trc_clr,
  output logic                        o_trc_vld,
  input  logic                        i_trc_rdy,
  output logic [DATA_W-1:0]           o_trc_pc,
  output logic [NUM_REGS-1:0]         o_trc_reg_mask,
  output logic                        o_trc_pred_wr,
  output logic                        o_trc_pred,
  output logic [NUM_PINS-1:0]         o_trc_pin_mask,
  output logic [TS_W-1:0]             o_trc_ts,
  output logic [$clog2(DEPTH):0]      o_trc_cnt,
  output logic                        o_trc_ovf,
  output logic [7:0]                  o_trc_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]   live_pc_q, live_pc_d;
  logic [NUM_REGS-1:0] live_mask_q, live_mask_d;
  logic                live_pwr_q, live_pwr_d;
  logic                live_pred_q, live_pred_d;
  logic [NUM_PINS-1:0] live_pin_q, live_pin_d;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          drop_q, drop_d;

  logic [DATA_W-1:0]   mem_pc_q   [DEPTH];
  logic [NUM_REGS-1:0] mem_mask_q [DEPTH];
  logic                mem_pwr_q  [DEPTH];
  logic                mem_pred_q [DEPTH];
  logic [NUM_PINS-1:0] mem_pin_q  [DEPTH];

  logic [DATA_W-1:0]   rec_pc;
  logic [NUM_REGS-1:0] rec_mask, reg_bit;
  logic                rec_pwr, rec_pred;
  logic [NUM_PINS-1:0] rec_pin;
  logic                full, pop, push, drop, wr_en;

  // Same-cycle events fold into the record; r0 writes never show up in the mask.
  assign reg_bit  = (i_trc_reg_wr && i_trc_reg_idx != '0) ? (NUM_REGS'(1) << i_trc_reg_idx) : '0;
  assign rec_pc   = i_trc_new ? i_trc_pc : live_pc_q;
  assign rec_mask = live_mask_q | reg_bit;
  assign rec_pwr  = live_pwr_q | i_trc_pred_wr;
  assign rec_pred = i_trc_pred_wr ? i_trc_pred_val : live_pred_q;
  assign rec_pin  = live_pin_q | i_trc_pin_wr;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign pop   = (cnt_q != '0) && i_trc_rdy;
  assign push  = i_trc_retire && (!full || pop);
  assign drop  = i_trc_retire && full && !pop;
  assign wr_en = push && !i_trc_clr;

  always_comb begin
    live_pc_d   = rec_pc;
    live_mask_d = rec_mask;
    live_pwr_d  = rec_pwr;
    live_pred_d = rec_pred;
    live_pin_d  = rec_pin;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    if (i_trc_clr) begin
      live_pc_d   = '0;
      live_mask_d = '0;
      live_pwr_d  = 1'b0;
      live_pred_d = 1'b0;
      live_pin_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      drop_d      = '0;
    end else begin
      if (i_trc_retire) begin
        live_mask_d = '0;
        live_pwr_d  = 1'b0;
        live_pred_d = 1'b0;
        live_pin_d  = '0;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_trc_gck or negedge i_trc_rst_n) begin
    if (!i_trc_rst_n) begin
      live_pc_q   <= '0;
      live_mask_q <= '0;
      live_pwr_q  <= 1'b0;
      live_pred_q <= 1'b0;
      live_pin_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_mask_q[i] <= '0;
        mem_pwr_q[i]  <= 1'b0;
        mem_pred_q[i] <= 1'b0;
        mem_pin_q[i]  <= '0;
      end
    end else begin
      live_pc_q   <= live_pc_d;
      live_mask_q <= live_mask_d;
      live_pwr_q  <= live_pwr_d;
      live_pred_q <= live_pred_d;
      live_pin_q  <= live_pin_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
      if (wr_en) begin
        mem_pc_q[wr_ptr_q]   <= rec_pc;
        mem_mask_q[wr_ptr_q] <= rec_mask;
        mem_pwr_q[wr_ptr_q]  <= rec_pwr;
        mem_pred_q[wr_ptr_q] <= rec_pred;
        mem_pin_q[wr_ptr_q]  <= rec_pin;
      end
    end
  end

`ifdef IDLI_TRC_TSTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0] mem_ts_q [DEPTH];

  // Free-running; deliberately untouched by clear.
  always_comb ts_d = ts_q + 1'b1;

  always_ff @(posedge i_trc_gck or negedge i_trc_rst_n) begin
    if (!i_trc_rst_n) begin
      ts_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_ts_q[i] <= '0;
    end else begin
      ts_q <= ts_d;
      if (wr_en) mem_ts_q[wr_ptr_q] <= ts_q;
    end
  end

  assign o_trc_ts = mem_ts_q[rd_ptr_q];
`else
  assign o_trc_ts = '0;
`endif

  assign o_trc_vld      = (cnt_q != '0);
  assign o_trc_pc       = mem_pc_q[rd_ptr_q];
  assign o_trc_reg_mask = mem_mask_q[rd_ptr_q];
  assign o_trc_pred_wr  = mem_pwr_q[rd_ptr_q];
  assign o_trc_pred     = mem_pred_q[rd_ptr_q];
  assign o_trc_pin_mask = mem_pin_q[rd_ptr_q];
  assign o_trc_cnt      = cnt_q;
  assign o_trc_ovf      = ovf_q;
  assign o_trc_drop_cnt = drop_q;

endmodule
